pio_arbiter: RTL and testbench

Two-master arbiter that shares the single PIO register bus (addr/data_in/data_out/wren/rden/ce) between requester 0 (CPU core) and requester 1 (DMA/sequencer). It converts a simple req/ack handshake per master into correctly timed PIO bus cycles, including the PIO's two-cycle read (latch then drive). Instantiated between the masters and the `pio` block; it is the only driver of the PIO bus control signals.

---
 rtl/pio_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_pio_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pio_arbiter.sv
// Two-master arbiter for the shared PIO register bus: turns per-master req/ack
// handshakes into PIO write cycles and two-cycle (latch, then drive) read cycles.
module pio_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m0_we,
  input  logic       m1_we,
  input  logic [3:0] m0_addr,
  input  logic [3:0] m1_addr,
  input  logic [7:0] m0_wdata,
  input  logic [7:0] m1_wdata,
  output logic [7:0] m0_rdata,
  output logic [7:0] m1_rdata,
  output logic       m0_ack,
  output logic       m1_ack,
  output logic [3:0] pio_addr,
  output logic [7:0] pio_wdata,
  input  logic [7:0] pio_rdata,
  output logic       pio_wren,
  output logic       pio_rden,
  output logic       pio_ce
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic       we_q, we_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] m0_rdata_q, m0_rdata_d;
  logic [7:0] m1_rdata_q, m1_rdata_d;
  logic       m0_ack_q, m0_ack_d;
  logic       m1_ack_q, m1_ack_d;
  logic [3:0] pio_addr_q, pio_addr_d;
  logic [7:0] pio_wdata_q, pio_wdata_d;
  logic       pio_wren_q, pio_wren_d;
  logic       pio_rden_q, pio_rden_d;
  logic       pio_ce_q, pio_ce_d;

  logic       sel_s;
  logic       sel_we_s;
  logic [3:0] sel_addr_s;
  logic [7:0] sel_wdata_s;

  // Pick the winning master among the raw requests and mux its command
  always_comb begin
    sel_s = 1'b0;
    if (m0_req && m1_req) begin
      if (FIXED_PRIO != 0) begin
        sel_s = 1'b0;
      end else begin
        sel_s = ~last_q;
      end
    end else if (m1_req) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    sel_we_s    = sel_s ? m1_we    : m0_we;
    sel_addr_s  = sel_s ? m1_addr  : m0_addr;
    sel_wdata_s = sel_s ? m1_wdata : m0_wdata;
  end

  // Next-state, command latch and read-data capture
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d   = sel_s;
          last_d  = sel_s;
          we_d    = sel_we_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          // Addresses 8..15 have no PIO port behind them: answer without a bus cycle
          if (sel_addr_s[3]) begin
            state_d = DONE;
            if (!sel_we_s && sel_s) begin
              m1_rdata_d = 8'h00;
            end else if (!sel_we_s) begin
              m0_rdata_d = 8'h00;
            end else begin
              m0_rdata_d = m0_rdata_q;
            end
          end else if (sel_we_s) begin
            state_d = WR;
          end else begin
            state_d = RD1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR:   state_d = DONE;
      RD1:  state_d = RD2;
      RD2: begin
        state_d = DONE;
        if (gnt_q) begin
          m1_rdata_d = pio_rdata;
        end else begin
          m0_rdata_d = pio_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes and acks are decoded from the state being entered, so they register cleanly
  always_comb begin
    pio_ce_d    = 1'b0;
    pio_wren_d  = 1'b0;
    pio_rden_d  = 1'b0;
    pio_addr_d  = 4'h0;
    pio_wdata_d = 8'h00;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    case (state_d)
      WR: begin
        pio_ce_d    = 1'b1;
        pio_wren_d  = 1'b1;
        pio_addr_d  = addr_d;
        pio_wdata_d = wdata_d;
      end
      RD1, RD2: begin
        pio_ce_d   = 1'b1;
        pio_rden_d = 1'b1;
        pio_addr_d = addr_d;
      end
      DONE: begin
        m0_ack_d = ~gnt_d;
        m1_ack_d = gnt_d;
      end
      default: pio_ce_d = 1'b0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= 4'h0;
      wdata_q     <= 8'h00;
      m0_rdata_q  <= 8'h00;
      m1_rdata_q  <= 8'h00;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      pio_addr_q  <= 4'h0;
      pio_wdata_q <= 8'h00;
      pio_wren_q  <= 1'b0;
      pio_rden_q  <= 1'b0;
      pio_ce_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      pio_addr_q  <= pio_addr_d;
      pio_wdata_q <= pio_wdata_d;
      pio_wren_q  <= pio_wren_d;
      pio_rden_q  <= pio_rden_d;
      pio_ce_q    <= pio_ce_d;
    end
  end

  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign pio_addr  = pio_addr_q;
  assign pio_wdata = pio_wdata_q;
  assign pio_wren  = pio_wren_q;
  assign pio_rden  = pio_rden_q;
  assign pio_ce    = pio_ce_q;

endmodule

// File: tb/tb_pio_arbiter.sv
// Random-stimulus bench for pio_arbiter: a round-robin and a fixed-priority instance,
// each checked every cycle against a transaction-level schedule and a PIO register model.
module tb_pio_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst      [2];
  logic       req      [2][2];
  logic       we       [2][2];
  logic [3:0] addr     [2][2];
  logic [7:0] wdata    [2][2];
  logic [7:0] rdata    [2][2];
  logic       ack      [2][2];
  logic [3:0] p_addr   [2];
  logic [7:0] p_wdata  [2];
  logic [7:0] p_rdata  [2];
  logic       p_wren   [2];
  logic       p_rden   [2];
  logic       p_ce     [2];

  pio_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst[0]),
    .m0_req(req[0][0]), .m1_req(req[0][1]), .m0_we(we[0][0]), .m1_we(we[0][1]),
    .m0_addr(addr[0][0]), .m1_addr(addr[0][1]), .m0_wdata(wdata[0][0]), .m1_wdata(wdata[0][1]),
    .m0_rdata(rdata[0][0]), .m1_rdata(rdata[0][1]), .m0_ack(ack[0][0]), .m1_ack(ack[0][1]),
    .pio_addr(p_addr[0]), .pio_wdata(p_wdata[0]), .pio_rdata(p_rdata[0]),
    .pio_wren(p_wren[0]), .pio_rden(p_rden[0]), .pio_ce(p_ce[0])
  );

  pio_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst[1]),
    .m0_req(req[1][0]), .m1_req(req[1][1]), .m0_we(we[1][0]), .m1_we(we[1][1]),
    .m0_addr(addr[1][0]), .m1_addr(addr[1][1]), .m0_wdata(wdata[1][0]), .m1_wdata(wdata[1][1]),
    .m0_rdata(rdata[1][0]), .m1_rdata(rdata[1][1]), .m0_ack(ack[1][0]), .m1_ack(ack[1][1]),
    .pio_addr(p_addr[1]), .pio_wdata(p_wdata[1]), .pio_rdata(p_rdata[1]),
    .pio_wren(p_wren[1]), .pio_rden(p_rden[1]), .pio_ce(p_ce[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = -1;

  logic [7:0] pio_mem   [2][8];
  logic [7:0] ref_mem   [2][8];
  bit         prev_rd   [2];
  logic [3:0] prev_addr [2];

  bit         pend      [2][2];
  bit         granted   [2][2];
  bit         t_we      [2][2];
  logic [3:0] t_addr    [2][2];
  logic [7:0] t_wdata   [2][2];
  int         ack_cyc   [2][2];
  logic [7:0] exp_rdata [2][2];
  logic [7:0] rd_result [2][2];

  int         free_cyc  [2];
  int         last_gnt  [2];
  int         n_mid     [2];
  bit         cur_v     [2];
  int         cur_g     [2];
  bit         cur_we    [2];
  logic [3:0] cur_addr  [2];
  logic [7:0] cur_wdata [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic new_txn(input int i, input int m, input bit wr_only);
    pend[i][m]    = 1'b1;
    t_we[i][m]    = wr_only ? 1'b1 : 1'($urandom_range(0, 1));
    t_addr[i][m]  = (!wr_only && $urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15))
                                                            : 4'($urandom_range(0, 7));
    t_wdata[i][m] = 8'($urandom);
  endtask

  // Masters hold stable fields while waiting; once granted they scramble them
  task automatic drive(input int i);
    for (int m = 0; m < 2; m++) begin
      req[i][m] = pend[i][m];
      if (pend[i][m] && !granted[i][m]) begin
        we[i][m]    = t_we[i][m];
        addr[i][m]  = t_addr[i][m];
        wdata[i][m] = t_wdata[i][m];
      end else begin
        we[i][m]    = 1'($urandom);
        addr[i][m]  = 4'($urandom);
        wdata[i][m] = 8'($urandom);
      end
    end
  endtask

  task automatic step(input int c);
    bit         e_ce, e_wr, e_rd, do_rst, contend;
    logic [3:0] e_addr;
    logic [7:0] e_wdata;
    int         g, lat;
    string      sfx;
    contend = (c < 40);
    for (int i = 0; i < 2; i++) begin
      sfx = (i == 0) ? "_rr" : "_fp";
      for (int m = 0; m < 2; m++) begin
        if (ack_cyc[i][m] == c && !t_we[i][m]) exp_rdata[i][m] = rd_result[i][m];
      end
      e_ce = 1'b0; e_wr = 1'b0; e_rd = 1'b0; e_addr = 4'h0; e_wdata = 8'h00;
      if (cur_v[i] && cur_we[i] && c == cur_g[i] + 1) begin
        e_ce = 1'b1; e_wr = 1'b1; e_addr = cur_addr[i]; e_wdata = cur_wdata[i];
      end
      if (cur_v[i] && !cur_we[i] && (c == cur_g[i] + 1 || c == cur_g[i] + 2)) begin
        e_ce = 1'b1; e_rd = 1'b1; e_addr = cur_addr[i];
      end
      chk({"m0_ack", sfx}, 8'(ack[i][0]), 8'(ack_cyc[i][0] == c));
      chk({"m1_ack", sfx}, 8'(ack[i][1]), 8'(ack_cyc[i][1] == c));
      chk({"m0_rdata", sfx}, rdata[i][0], exp_rdata[i][0]);
      chk({"m1_rdata", sfx}, rdata[i][1], exp_rdata[i][1]);
      chk({"pio_ce", sfx}, 8'(p_ce[i]), 8'(e_ce));
      chk({"pio_wren", sfx}, 8'(p_wren[i]), 8'(e_wr));
      chk({"pio_rden", sfx}, 8'(p_rden[i]), 8'(e_rd));
      chk({"pio_addr", sfx}, 8'(p_addr[i]), 8'(e_addr));
      chk({"pio_wdata", sfx}, p_wdata[i], e_wdata);
      chk({"wr_rd_excl", sfx}, 8'(p_wren[i] & p_rden[i]), 8'h00);

      // PIO model: writes land at end of cycle; a read latches, then drives next cycle
      if (p_ce[i] === 1'b1 && p_wren[i] === 1'b1) pio_mem[i][p_addr[i][2:0]] = p_wdata[i];
      p_rdata[i]   = prev_rd[i] ? pio_mem[i][prev_addr[i][2:0]] : 8'($urandom);
      prev_rd[i]   = (p_ce[i] === 1'b1 && p_rden[i] === 1'b1);
      prev_addr[i] = p_addr[i];

      for (int m = 0; m < 2; m++) begin
        if (ack_cyc[i][m] == c) begin
          pend[i][m] = 1'b0; granted[i][m] = 1'b0; ack_cyc[i][m] = -1;
        end
      end

      do_rst = 1'b0;
      if (c < 3) begin
        do_rst = 1'b1;
      end else if (cur_v[i] && !cur_we[i] && c == cur_g[i] + 2 && n_mid[i] < 6 &&
                   $urandom_range(0, 2) == 0) begin
        do_rst = 1'b1;
        n_mid[i]++;
      end
      rst[i] = !do_rst;
      if (do_rst) begin
        for (int m = 0; m < 2; m++) begin
          granted[i][m] = 1'b0; ack_cyc[i][m] = -1; exp_rdata[i][m] = 8'h00;
        end
        cur_v[i] = 1'b0; last_gnt[i] = 1; free_cyc[i] = c + 1;
      end

      for (int m = 0; m < 2; m++) begin
        if (!pend[i][m] && (contend || $urandom_range(0, 99) < 40)) new_txn(i, m, contend);
      end
      drive(i);

      if (!do_rst && c == free_cyc[i]) begin
        if (pend[i][0] || pend[i][1]) begin
          if (pend[i][0] && pend[i][1]) g = (i == 1) ? 0 : 1 - last_gnt[i];
          else g = pend[i][0] ? 0 : 1;
          last_gnt[i]   = g;
          granted[i][g] = 1'b1;
          lat = t_addr[i][g][3] ? 1 : (t_we[i][g] ? 2 : 3);
          ack_cyc[i][g] = c + lat;
          free_cyc[i]   = c + lat + 1;
          if (t_addr[i][g][3]) rd_result[i][g] = 8'h00;
          else if (!t_we[i][g]) rd_result[i][g] = ref_mem[i][t_addr[i][g][2:0]];
          else ref_mem[i][t_addr[i][g][2:0]] = t_wdata[i][g];
          cur_v[i]     = !t_addr[i][g][3];
          cur_g[i]     = c;
          cur_we[i]    = t_we[i][g];
          cur_addr[i]  = t_addr[i][g];
          cur_wdata[i] = t_wdata[i][g];
        end else begin
          free_cyc[i] = c + 1;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 8; a++) begin
        pio_mem[i][a] = 8'($urandom);
        ref_mem[i][a] = pio_mem[i][a];
      end
      for (int m = 0; m < 2; m++) begin
        new_txn(i, m, 1'b1);
        granted[i][m] = 1'b0; ack_cyc[i][m] = -1;
        exp_rdata[i][m] = 8'h00; rd_result[i][m] = 8'h00;
      end
      free_cyc[i] = 0; last_gnt[i] = 1; n_mid[i] = 0; cur_v[i] = 1'b0;
      cur_g[i] = -10; cur_we[i] = 1'b0; cur_addr[i] = 4'h0; cur_wdata[i] = 8'h00;
      prev_rd[i] = 1'b0; prev_addr[i] = 4'h0;
      p_rdata[i] = 8'h00;
      rst[i] = 1'b0;
      drive(i);
    end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      cyc = c;
      step(c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
